// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button conditioning stage and later
// button-driven labs: debounce FSM state encoding and default timing.
package button_debouncer_pkg;

   // Per-channel debounce FSM states
   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_CHANGING = 1'b1
   } db_state_e;

   // 1 ms sampling tick from a 100 MHz clock
   localparam int TICK_DIV_1MS_100MHZ    = 100000;
   localparam int DIV_WIDTH_1MS_100MHZ   = 17;
   // 10 ms of agreement at a 1 ms tick before a change is accepted
   localparam int DEFAULT_DEBOUNCE_TICKS = 10;
   localparam int DEFAULT_CNT_WIDTH      = 4;

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between raw inputs / downstream logic and the debouncer.
// There is no handshake here: btn_i is a free-running asynchronous level,
// and btn_o/rise_o/fall_o/tick_o are synchronous to clk and valid every
// cycle. state_o exposes each channel's FSM state (1 = CHANGING) for debug.
interface button_debouncer_if #(
   parameter int N_CH = 2
);

   logic [N_CH-1:0] btn_i;
   logic [N_CH-1:0] btn_o;
   logic [N_CH-1:0] rise_o;
   logic [N_CH-1:0] fall_o;
   logic [N_CH-1:0] state_o;
   logic            tick_o;

   // Side that drives the raw inputs and consumes the clean levels
   modport master (
      output btn_i,
      input  btn_o,
      input  rise_o,
      input  fall_o,
      input  state_o,
      input  tick_o
   );

   // Debouncer side
   modport slave (
      input  btn_i,
      output btn_o,
      output rise_o,
      output fall_o,
      output state_o,
      output tick_o
   );

endinterface

// File: rtl/button_debouncer_tick_gen.sv
// Sampling-tick generator: a divider that counts 0..TICK_DIV-1 and wraps.
// tick_o is high for exactly the cycle in which the divider sits at its
// last value, so the first tick appears TICK_DIV-1 cycles after reset.
module tick_gen
   import button_debouncer_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_1MS_100MHZ,
   parameter int DIV_WIDTH = DIV_WIDTH_1MS_100MHZ
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(TICK_DIV - 1);

   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] div_d;

   assign tick_o = (div_q == DIV_LAST);

   // Next divider value: wrap to zero on the tick cycle, never past DIV_LAST
   always_comb begin
      div_d = div_q + DIV_WIDTH'(1);
      if (tick_o) begin
         div_d = '0;
      end
   end

   // Divider register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Push-button / switch conditioner. Each channel runs a 2-FF synchroniser
// into a tick-sampled debounce FSM: a change on the synchronised input is
// only committed to btn_o after DEBOUNCE_TICKS consecutive ticks all see
// the new level. rise_o/fall_o pulse for the one cycle in which btn_o
// first shows the committed value.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int N_CH           = 2,
   parameter int TICK_DIV       = TICK_DIV_1MS_100MHZ,
   parameter int DIV_WIDTH      = DIV_WIDTH_1MS_100MHZ,
   parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
   parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   button_debouncer_if.slave  bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_TICKS - 1);

   logic tick;

   tick_gen #(
      .TICK_DIV  (TICK_DIV),
      .DIV_WIDTH (DIV_WIDTH)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   assign bus.tick_o = tick;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic                 sync1_q;
      logic                 sync2_q;
      db_state_e            state_q;
      logic [CNT_WIDTH-1:0] cnt_q;
      logic                 btn_q;
      logic                 rise_q;
      logic                 fall_q;

      // Two-flop synchroniser; only sync2_q is ever looked at downstream
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
         end else begin
            sync1_q <= bus.btn_i[k];
            sync2_q <= sync1_q;
         end
      end

      // Debounce FSM with its agreement counter, level and edge pulses
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (tick) begin
               case (state_q)
                  ST_STABLE: begin
                     if (sync2_q != btn_q) begin
                        state_q <= ST_CHANGING;
                        cnt_q   <= CNT_WIDTH'(1);
                     end
                  end
                  ST_CHANGING: begin
                     if (sync2_q == btn_q) begin
                        // Input went back before enough agreement: a bounce
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                     end else if (cnt_q == CNT_LAST) begin
                        // This tick completes the run of agreeing samples
                        btn_q   <= ~btn_q;
                        rise_q  <= ~btn_q;
                        fall_q  <= btn_q;
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                     end
                  end
               endcase
            end
         end
      end

      assign bus.btn_o[k]   = btn_q;
      assign bus.rise_o[k]  = rise_q;
      assign bus.fall_o[k]  = fall_q;
      assign bus.state_o[k] = state_q;
   end

endmodule
